// File: rtl/mux_pkg.sv
// Shared types and limits for the N-channel stream multiplexer family.
package mux_pkg;
  typedef enum logic {MUX_FIXED = 1'b0, MUX_RR = 1'b1} mux_mode_t;
  localparam int MUX_MAX_N = 16;
endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: picks the first requester after `last`,
// wrapping around; no grant when disabled or when nothing requests.
module rr_arbiter_n #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  input  logic                 enable,
  output logic [$clog2(N)-1:0] grant,
  output logic                 grant_valid
);
  localparam int SELW = $clog2(N);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    if (enable) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last) + k) % N;
        if (!grant_valid && req[idx]) begin
          grant       = SELW'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rr_mux_n.sv
// N-channel valid/ready multiplexer with fixed or round-robin selection and a
// one-entry output register. Define RR_MUX_LOCK_EN to add packet locking (in_last/out_last).
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [N-1:0]         in_last,
  output logic                 out_last,
`endif
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready
);
  localparam int SELW = $clog2(N);

  // Handshake: a word moves when valid && ready are both high at a rising edge.
  // in_ready is a function of grant and output-stage space only, never of in_valid
  // of non-granted channels; out_data is always a register output.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  last_q,      last_d;

  logic             rr_mode;
  logic             load_en;
  logic             xfer;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [SELW-1:0]  arb_grant;
  logic             arb_valid;
  logic             arb_en;
  logic             fix_valid;

  assign rr_mode   = (mux_mode_t'(mode) == MUX_RR);
  assign load_en   = !out_valid_q || out_ready;
  assign fix_valid = (int'(sel) < N) && in_valid[sel];

`ifdef RR_MUX_LOCK_EN
  logic            lock_q,     lock_d;
  logic [SELW-1:0] lock_src_q, lock_src_d;
  logic            out_last_q, out_last_d;
  assign arb_en = rr_mode && !lock_q;
`else
  assign arb_en = rr_mode;
`endif

  rr_arbiter_n #(.N(N)) u_arb (
    .req         (in_valid),
    .last        (last_q),
    .enable      (arb_en),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
`ifdef RR_MUX_LOCK_EN
    if (lock_q) begin
      grant       = lock_src_q;
      grant_valid = in_valid[lock_src_q];
    end else
`endif
    if (rr_mode) begin
      grant       = arb_grant;
      grant_valid = arb_valid;
    end else begin
      grant       = sel;
      grant_valid = fix_valid;
    end
  end

  assign xfer = grant_valid && load_en && !reset;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_src_d  = lock_src_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
      out_src_d   = grant;
      if (rr_mode) last_d = grant;
`ifdef RR_MUX_LOCK_EN
      lock_d     = !in_last[grant];
      lock_src_d = grant;
      out_last_d = in_last[grant];
`endif
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it: data/src keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_q      <= SELW'(N - 1);
`ifdef RR_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_src_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_src_q  <= lock_src_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
`ifdef RR_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif
endmodule
